// File: rtl/gshare_btb_predictor_pkg.sv
// Shared sizing, PC field bounds and 2-bit counter state constants for the gshare/BTB predictor.
package gshare_btb_predictor_pkg;

   localparam int PC_W            = 32;
   localparam int DEF_BTB_ENTRIES = 32;
   localparam int DEF_GHR_BITS    = 5;

   // Word-aligned PCs: index starts above the byte offset, tag takes everything above the index.
   localparam int IDX_LSB     = 2;
   localparam int DEF_IDX_MSB = IDX_LSB + DEF_GHR_BITS - 1;
   localparam int DEF_TAG_LSB = DEF_IDX_MSB + 1;
   localparam int TAG_MSB     = PC_W - 1;

   typedef enum logic [1:0] {
      SNT = 2'd0,
      WNT = 2'd1,
      WT  = 2'd2,
      ST  = 2'd3
   } ctr_state_e;

endpackage

// File: rtl/gshare_btb_predictor_sat_counter2_update.sv
// Next state of a 2-bit saturating counter: count up on taken, down on not-taken, clamp at SNT/ST.
// Purely combinational, no flow control.
module sat_counter2_update
   import gshare_btb_predictor_pkg::*;
(
   input  logic [1:0] cnt_i,
   input  logic       taken_i,
   output logic [1:0] cnt_o
);

   always_comb begin
      cnt_o = cnt_i;
      if (taken_i) begin
         if (cnt_i != ST) cnt_o = cnt_i + 2'd1;
      end else begin
         if (cnt_i != SNT) cnt_o = cnt_i - 2'd1;
      end
   end

endmodule

// File: rtl/gshare_btb_predictor.sv
// Gshare direction predictor with a direct-mapped BTB; zero-cycle combinational lookup.
// Updates land on the next rising edge; always ready, no backpressure.
module gshare_btb_predictor
   import gshare_btb_predictor_pkg::*;
#(
   parameter int BTB_ENTRIES = DEF_BTB_ENTRIES,
   parameter int GHR_BITS    = DEF_GHR_BITS
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PC_W-1:0]     if_pc,
   output logic                pred_taken,
   output logic [PC_W-1:0]     pred_next_pc,
   output logic [GHR_BITS-1:0] pred_ghr,
   input  logic                update_valid,
   input  logic [PC_W-1:0]     update_pc,
   input  logic                update_taken,
   input  logic [PC_W-1:0]     update_target,
   input  logic [GHR_BITS-1:0] update_ghr
);

   localparam int IDX_W  = $clog2(BTB_ENTRIES);
   localparam int IDX_HI = IDX_LSB + IDX_W - 1;
   localparam int TAG_LO = IDX_HI + 1;
   localparam int TAG_W  = TAG_MSB - TAG_LO + 1;

   logic                valid_q [BTB_ENTRIES];
   logic [TAG_W-1:0]    tag_q   [BTB_ENTRIES];
   logic [PC_W-1:0]     tgt_q   [BTB_ENTRIES];
   logic [1:0]          pht_q   [BTB_ENTRIES];
   logic [GHR_BITS-1:0] ghr_q;
   logic [GHR_BITS-1:0] ghr_d;
   logic [1:0]          pht_d;

   logic [IDX_W-1:0]    lk_idx;
   logic [IDX_W-1:0]    lk_pht_idx;
   logic [TAG_W-1:0]    lk_tag;
   logic                lk_hit;
   logic [IDX_W-1:0]    upd_idx;
   logic [IDX_W-1:0]    upd_pht_idx;
   logic                unused_upd_bits;

   assign unused_upd_bits = ^update_pc[IDX_LSB-1:0];

   // Lookup reads only registered state, so a same-cycle update is never bypassed.
   assign lk_idx       = if_pc[IDX_HI:IDX_LSB];
   assign lk_tag       = if_pc[TAG_MSB:TAG_LO];
   assign lk_pht_idx   = lk_idx ^ ghr_q;
   assign lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign pred_taken   = lk_hit && pht_q[lk_pht_idx][1];
   assign pred_next_pc = pred_taken ? tgt_q[lk_idx] : if_pc + 32'd4;
   assign pred_ghr     = ghr_q;

   assign upd_idx     = update_pc[IDX_HI:IDX_LSB];
   assign upd_pht_idx = upd_idx ^ update_ghr;
   // History is rebuilt from the resolved snapshot, which also repairs it after a mispredict.
   assign ghr_d       = {update_ghr[GHR_BITS-2:0], update_taken};

   sat_counter2_update u_ctr (
      .cnt_i   (pht_q[upd_pht_idx]),
      .taken_i (update_taken),
      .cnt_o   (pht_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         ghr_q <= '0;
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            pht_q[i]   <= WNT;
         end
      end else if (update_valid) begin
         ghr_q              <= ghr_d;
         pht_q[upd_pht_idx] <= pht_d;
         if (update_taken) valid_q[upd_idx] <= 1'b1;
      end
   end

   // Tags and targets are not reset; a cleared valid bit makes them irrelevant.
   always_ff @(posedge clk) begin
      if (!reset && update_valid && update_taken) begin
         tag_q[upd_idx] <= update_pc[TAG_MSB:TAG_LO];
         tgt_q[upd_idx] <= update_target;
      end
   end

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Self-checking bench for gshare_btb_predictor: directed scenarios plus randomized traffic vs a reference model.
module tb_gshare_btb_predictor;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_next_pc;
   logic [4:0]  pred_ghr;
   logic        update_valid;
   logic [31:0] update_pc;
   logic        update_taken;
   logic [31:0] update_target;
   logic [4:0]  update_ghr;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: plain arrays indexed by word address modulo table size.
   bit          m_valid [32];
   int unsigned m_tag   [32];
   logic [31:0] m_tgt   [32];
   int          m_pht   [32];
   int unsigned m_ghr;

   always #5 clk = ~clk;

   gshare_btb_predictor dut (
      .clk           (clk),
      .reset         (reset),
      .if_pc         (if_pc),
      .pred_taken    (pred_taken),
      .pred_next_pc  (pred_next_pc),
      .pred_ghr      (pred_ghr),
      .update_valid  (update_valid),
      .update_pc     (update_pc),
      .update_taken  (update_taken),
      .update_target (update_target),
      .update_ghr    (update_ghr)
   );

   function automatic bit m_taken(input logic [31:0] pc);
      int unsigned idx;
      idx = (pc / 4) % 32;
      return m_valid[idx] && (m_tag[idx] == pc / 128) && (m_pht[idx ^ m_ghr] >= 2);
   endfunction

   function automatic logic [31:0] m_next(input logic [31:0] pc);
      return m_taken(pc) ? m_tgt[(pc / 4) % 32] : pc + 32'd4;
   endfunction

   task automatic tick();
      int unsigned idx;
      int unsigned p;
      @(posedge clk);
      if (reset) begin
         m_ghr = 0;
         for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_pht[i]   = 1;
         end
      end else if (update_valid) begin
         idx = (update_pc / 4) % 32;
         p   = idx ^ int'(update_ghr);
         if (update_taken) begin
            if (m_pht[p] < 3) m_pht[p] = m_pht[p] + 1;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = update_pc / 128;
            m_tgt[idx]   = update_target;
         end else if (m_pht[p] > 0) begin
            m_pht[p] = m_pht[p] - 1;
         end
         m_ghr = (int'(update_ghr) * 2 + int'(update_taken)) % 32;
      end
      #1;
   endtask

   task automatic drive_upd(input bit v, input logic [31:0] pc, input bit t,
                            input logic [31:0] tgt, input logic [4:0] g);
      update_valid  = v;
      update_pc     = pc;
      update_taken  = t;
      update_target = tgt;
      update_ghr    = g;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 5'd0);
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      if_pc = 32'h100;
      drive_upd(1'b1, 32'h100, 1'b1, 32'h500, 5'd3);
      tick();
      #1;
      n_tests++;
      if (pred_taken !== 1'b0 || pred_next_pc !== 32'h104 || pred_ghr !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_hold: taken=%0b next=%h ghr=%0d required 0/00000104/0",
                  pred_taken, pred_next_pc, pred_ghr);
      end
      tick();
      reset = 1'b0;
      drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 5'd0);
      for (int a = 0; a <= 32'h7C; a += 4) begin
         if_pc = a;
         #1;
         n_tests++;
         if (pred_taken !== 1'b0 || pred_next_pc !== a + 4 || pred_ghr !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_sweep pc=%h: taken=%0b next=%h ghr=%0d required 0/%h/0",
                     a, pred_taken, pred_next_pc, pred_ghr, a + 4);
         end
      end
   endtask

   task automatic test_history_align();
      do_reset();
      drive_upd(1'b1, 32'h10, 1'b1, 32'h40, 5'd0);
      tick();
      drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 5'd0);
      if_pc = 32'h10;
      #1;
      n_tests++;
      if (pred_ghr !== 5'd1 || pred_taken !== 1'b0 || pred_next_pc !== 32'h14) begin
         n_fail++;
         $display("FAIL hist_first: ghr=%0d taken=%0b next=%h required 1/0/00000014",
                  pred_ghr, pred_taken, pred_next_pc);
      end
      drive_upd(1'b1, 32'h10, 1'b1, 32'h40, 5'd1);
      tick();
      drive_upd(1'b1, 32'h10, 1'b1, 32'h40, 5'd0);
      tick();
      drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 5'd0);
      #1;
      n_tests++;
      if (pred_ghr !== 5'd1 || pred_taken !== 1'b1 || pred_next_pc !== 32'h40) begin
         n_fail++;
         $display("FAIL hist_aligned: ghr=%0d taken=%0b next=%h required 1/1/00000040",
                  pred_ghr, pred_taken, pred_next_pc);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drive_upd(1'b1, 32'h20, 1'b0, 32'hDEAD_0000, 5'd0);
         tick();
      end
      drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 5'd0);
      if_pc = 32'h20;
      #1;
      n_tests++;
      if (pred_taken !== 1'b0 || pred_next_pc !== 32'h24 || pred_ghr !== 5'd0) begin
         n_fail++;
         $display("FAIL nt_no_alloc: taken=%0b next=%h ghr=%0d required 0/00000024/0",
                  pred_taken, pred_next_pc, pred_ghr);
      end
      // One taken step from a floored counter must land on 01, not 11.
      drive_upd(1'b1, 32'h20, 1'b1, 32'h300, 5'd0);
      tick();
      drive_upd(1'b1, 32'h24, 1'b0, 32'h0, 5'd0);
      tick();
      drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 5'd0);
      #1;
      n_tests++;
      if (pred_taken !== 1'b0 || pred_next_pc !== 32'h24) begin
         n_fail++;
         $display("FAIL sat_floor: taken=%0b next=%h required 0/00000024", pred_taken, pred_next_pc);
      end
      drive_upd(1'b1, 32'h20, 1'b1, 32'h300, 5'd31);
      tick();
      drive_upd(1'b1, 32'h20, 1'b1, 32'h300, 5'd0);
      tick();
      drive_upd(1'b1, 32'h24, 1'b0, 32'h0, 5'd0);
      tick();
      drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 5'd0);
      #1;
      n_tests++;
      if (pred_taken !== 1'b1 || pred_next_pc !== 32'h300) begin
         n_fail++;
         $display("FAIL sat_climb: taken=%0b next=%h required 1/00000300", pred_taken, pred_next_pc);
      end
   endtask

   task automatic test_alias();
      do_reset();
      drive_upd(1'b1, 32'h10, 1'b1, 32'h40, 5'd0);
      tick();
      drive_upd(1'b1, 32'h90, 1'b1, 32'h200, 5'd0);
      tick();
      drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 5'd0);
      if_pc = 32'h10;
      #1;
      n_tests++;
      if (pred_taken !== 1'b0 || pred_next_pc !== 32'h14) begin
         n_fail++;
         $display("FAIL tag_alias: taken=%0b next=%h required 0/00000014", pred_taken, pred_next_pc);
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      if_pc = 32'h30;
      drive_upd(1'b1, 32'h30, 1'b1, 32'h100, 5'd31);
      #1;
      n_tests++;
      if (pred_taken !== 1'b0 || pred_next_pc !== 32'h34) begin
         n_fail++;
         $display("FAIL same_cycle_old: taken=%0b next=%h required 0/00000034", pred_taken, pred_next_pc);
      end
      tick();
      drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 5'd0);
      #1;
      n_tests++;
      if (pred_taken !== 1'b1 || pred_next_pc !== 32'h100 || pred_ghr !== 5'd31) begin
         n_fail++;
         $display("FAIL same_cycle_new: taken=%0b next=%h ghr=%0d required 1/00000100/31",
                  pred_taken, pred_next_pc, pred_ghr);
      end
   endtask

   task automatic test_reset_mid_stream();
      do_reset();
      for (int k = 0; k < 20; k++) begin
         drive_upd(1'b1, 32'h44, 1'b1, 32'h880, 5'($urandom_range(0, 31)));
         tick();
      end
      reset = 1'b1;
      drive_upd(1'b1, 32'h48, 1'b1, 32'h990, 5'd7);
      tick();
      reset = 1'b0;
      drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 5'd0);
      for (int a = 32'h40; a <= 32'h4C; a += 4) begin
         if_pc = a;
         #1;
         n_tests++;
         if (pred_taken !== 1'b0 || pred_next_pc !== a + 4 || pred_ghr !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_mid pc=%h: taken=%0b next=%h ghr=%0d required 0/%h/0",
                     a, pred_taken, pred_next_pc, pred_ghr, a + 4);
         end
      end
      // Counters must restart at 01: a single taken update is enough to predict taken.
      drive_upd(1'b1, 32'h44, 1'b1, 32'h880, 5'd31);
      tick();
      drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 5'd0);
      if_pc = 32'h44;
      #1;
      n_tests++;
      if (pred_taken !== 1'b1 || pred_next_pc !== 32'h880) begin
         n_fail++;
         $display("FAIL reset_pht_wnt: taken=%0b next=%h required 1/00000880", pred_taken, pred_next_pc);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 600; k++) begin
         if_pc = 32'($urandom_range(0, 255)) * 4;
         drive_upd($urandom_range(0, 99) < 70, 32'($urandom_range(0, 255)) * 4,
                   1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
                   ($urandom_range(0, 1) == 1) ? pred_ghr : 5'($urandom_range(0, 31)));
         reset = ($urandom_range(0, 99) < 3);
         #1;
         n_tests++;
         if (pred_taken !== m_taken(if_pc) || pred_next_pc !== m_next(if_pc) ||
             pred_ghr !== 5'(m_ghr)) begin
            n_fail++;
            $display("FAIL random[%0d] pc=%h: taken=%0b next=%h ghr=%0d required %0b/%h/%0d",
                     k, if_pc, pred_taken, pred_next_pc, pred_ghr,
                     m_taken(if_pc), m_next(if_pc), m_ghr);
         end
         tick();
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      if_pc = 32'h0;
      drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 5'd0);
      m_ghr = 0;
      for (int i = 0; i < 32; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = 0;
         m_tgt[i]   = 32'h0;
         m_pht[i]   = 1;
      end
      #2;
      test_reset();
      test_history_align();
      test_saturate();
      test_alias();
      test_same_cycle();
      test_reset_mid_stream();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
